// File: rtl/anita_multi_buffer_manager.sv
// Trigger-to-buffer manager: round-robin analog buffer allocation, HOLD control,
// digitize command generation, programmable holdoff and lost-trigger counting.
module anita_multi_buffer_manager #(
  parameter int NUM_BUFFERS    = 4,
  parameter int NUM_TRIG       = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int BUF_W          = $clog2(NUM_BUFFERS)
) (
  input  logic                   clk250_i,
  input  logic                   rst_i,
  input  logic [NUM_TRIG-1:0]    trig_i,
  input  logic [NUM_TRIG-1:0]    trig_mask_i,
  input  logic                   clear_i,
  input  logic [BUF_W-1:0]       clear_buffer_i,
  output logic                   digitize_o,
  output logic [BUF_W-1:0]       digitize_buffer_o,
  output logic [NUM_TRIG-1:0]    digitize_source_o,
  output logic [NUM_BUFFERS-1:0] buffer_status_o,
  output logic [NUM_BUFFERS-1:0] HOLD_o,
  output logic                   dead_o,
  output logic [15:0]            lost_count_o,
  output logic                   state_dbg_o
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUFFERS - 1);

  typedef enum logic {S_IDLE, S_HOLDOFF} state_t;

  state_t                 r_state;
  logic [BUF_W-1:0]       r_wr_ptr;
  logic [NUM_BUFFERS-1:0] r_status;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_digitize;
  logic [BUF_W-1:0]       r_dig_buf;
  logic [NUM_TRIG-1:0]    r_dig_src;
  logic [15:0]            r_lost;

  logic [NUM_TRIG-1:0]    w_src;
  logic                   w_req;
  logic                   w_accept;
  logic [NUM_BUFFERS-1:0] w_clear_mask;
  logic [NUM_BUFFERS-1:0] w_set_mask;

  assign w_src = trig_i & ~trig_mask_i;
  assign w_req = |w_src;
  // Acceptance looks at the registered status, so a same-cycle clear of the
  // next buffer cannot rescue the trigger.
  assign w_accept = (r_state == S_IDLE) && w_req && !r_status[r_wr_ptr];

  // Out-of-range clear indices match no bit and are therefore ignored.
  always_comb begin
    w_clear_mask = '0;
    w_set_mask   = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      w_clear_mask[i] = clear_i && (clear_buffer_i == BUF_W'(i));
      w_set_mask[i]   = w_accept && (r_wr_ptr == BUF_W'(i));
    end
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_status   <= '0;
      r_cnt      <= '0;
      r_digitize <= 1'b0;
      r_dig_buf  <= '0;
      r_dig_src  <= '0;
      r_lost     <= '0;
    end else begin
      r_digitize <= w_accept;
      r_status   <= (r_status & ~w_clear_mask) | w_set_mask;
      if (w_accept) begin
        r_dig_buf <= r_wr_ptr;
        r_dig_src <= w_src;
      end
      if (w_req && !w_accept && (r_lost != 16'hFFFF)) begin
        r_lost <= r_lost + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == '0) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= (r_wr_ptr == LAST_BUF) ? '0 : r_wr_ptr + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign digitize_o        = r_digitize;
  assign digitize_buffer_o = r_dig_buf;
  assign digitize_source_o = r_dig_src;
  assign buffer_status_o   = r_status;
  assign HOLD_o            = r_status;
  assign dead_o            = (r_state == S_HOLDOFF) | r_status[r_wr_ptr];
  assign lost_count_o      = r_lost;
  assign state_dbg_o       = r_state;

endmodule
